// File: rtl/mem_image_dumper_pkg.sv
// Shared types and constants for the PDP-11 load-image dumper.
package mem_image_dumper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_REC,
    FETCH,
    WAIT,
    DATA_REC,
    PC_REC,
    FIN
  } dump_state_t;

  localparam logic [7:0] CH_AT      = 8'h40;
  localparam logic [7:0] CH_DASH    = 8'h2D;
  localparam logic [7:0] CH_STAR    = 8'h2A;
  localparam int         OCT_DIGITS = 6;

  // ASCII octal digit at record position pos (1 = most significant digit).
  function automatic logic [7:0] oct_char(input logic [15:0] v, input logic [2:0] pos);
    logic [17:0] w;
    logic [2:0]  d;
    w = {2'b00, v};
    case (pos)
      3'd1:    d = w[17:15];
      3'd2:    d = w[14:12];
      3'd3:    d = w[11:9];
      3'd4:    d = w[8:6];
      3'd5:    d = w[5:3];
      default: d = w[2:0];
    endcase
    return {5'b00110, d};
  endfunction

endpackage

// File: rtl/mem_image_dumper_oct_rec_ser.sv
// Serialises one record: prefix char, six octal digits, terminator.
module oct_rec_ser
  import mem_image_dumper_pkg::*;
#(
  parameter logic [7:0] NEWLINE = 8'h0A
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [7:0]  prefix,
  input  logic [15:0] value,
  input  logic        tx_ready,
  output logic        idle,
  output logic        rec_done,
  output logic [7:0]  tx_data,
  output logic        tx_valid
);

  localparam logic [2:0] IDX_NL = 3'(OCT_DIGITS + 1);

  logic        active_q, active_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  prefix_q, prefix_d;
  logic [15:0] value_q, value_d;
  logic        xfer;

  assign xfer     = active_q & tx_ready;
  assign rec_done = xfer & (idx_q == IDX_NL);
  assign idle     = ~active_q;
  assign tx_valid = active_q;

  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    prefix_d = prefix_q;
    value_d  = value_q;
    if (xfer) begin
      if (idx_q == IDX_NL) begin
        active_d = 1'b0;
        idx_d    = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
    // A new record may be loaded on the cycle the previous one finishes.
    if (load && (!active_q || rec_done)) begin
      active_d = 1'b1;
      idx_d    = 3'd0;
      prefix_d = prefix;
      value_d  = value;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    if (active_q) begin
      if (idx_q == 3'd0)        tx_data = prefix_q;
      else if (idx_q == IDX_NL) tx_data = NEWLINE;
      else                      tx_data = oct_char(value_q, idx_q);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      idx_q    <= 3'd0;
      prefix_q <= 8'h00;
      value_q  <= 16'h0000;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      prefix_q <= prefix_d;
      value_q  <= value_d;
    end
  end

endmodule

// File: rtl/mem_image_dumper.sv
// Dumps a block of memory as '@' address, '-' data and '*' PC records of octal ASCII.
module mem_image_dumper
  import mem_image_dumper_pkg::*;
#(
  parameter int         CNT_W   = 16,
  parameter logic [7:0] NEWLINE = 8'h0A,
  parameter bit         EMIT_PC = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      start_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic [15:0]      start_pc,
  output logic             mem_rd,
  output logic [15:0]      mem_addr,
  input  logic [15:0]      mem_rdata,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  dump_state_t      state_q, state_d;
  logic [15:0]      cur_q, cur_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [15:0]      pc_q, pc_d;
  logic             ser_load, ser_idle, rec_done;
  logic [7:0]       ser_prefix;
  logic [15:0]      ser_value;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    pc_d       = pc_q;
    ser_load   = 1'b0;
    ser_prefix = CH_AT;
    ser_value  = 16'h0000;
    case (state_q)
      IDLE: if (start) begin
        cur_d     = start_addr & 16'hFFFE;
        rem_d     = word_count;
        pc_d      = start_pc;
        ser_load  = 1'b1;
        ser_value = start_addr & 16'hFFFE;
        state_d   = ADDR_REC;
      end
      ADDR_REC: if (rec_done) begin
        if (rem_q != '0) begin
          state_d = FETCH;
        end else if (EMIT_PC) begin
          ser_load   = 1'b1;
          ser_prefix = CH_STAR;
          ser_value  = pc_q;
          state_d    = PC_REC;
        end else begin
          state_d = FIN;
        end
      end
      FETCH: state_d = WAIT;
      // The serialiser's value register doubles as the read-data holding register.
      WAIT: if (ser_idle) begin
        ser_load   = 1'b1;
        ser_prefix = CH_DASH;
        ser_value  = mem_rdata;
        state_d    = DATA_REC;
      end
      DATA_REC: if (rec_done) begin
        cur_d = cur_q + 16'd2;
        rem_d = rem_q - CNT_ONE;
        if (rem_q != CNT_ONE) begin
          state_d = FETCH;
        end else if (EMIT_PC) begin
          ser_load   = 1'b1;
          ser_prefix = CH_STAR;
          ser_value  = pc_q;
          state_d    = PC_REC;
        end else begin
          state_d = FIN;
        end
      end
      PC_REC: if (rec_done) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q   <= 16'h0000;
      rem_q   <= '0;
      pc_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      pc_q    <= pc_d;
    end
  end

  assign mem_rd   = (state_q == FETCH);
  assign mem_addr = cur_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);

  oct_rec_ser #(
    .NEWLINE (NEWLINE)
  ) u_ser (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (ser_load),
    .prefix   (ser_prefix),
    .value    (ser_value),
    .tx_ready (tx_ready),
    .idle     (ser_idle),
    .rec_done (rec_done),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

endmodule
